// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the femtoRV32 integer register file.
// Holds the default geometry of the register file, the debug read FSM
// state type and the address of the hardwired-zero register x0.
package regfile_2r1w_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 32;

  // Register x0 always reads as zero and is never stored.
  localparam int X0_ADDR = 0;

  // Debug read port: IDLE waits for a request, RESP presents the ack pulse.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus interface of the register file.
// Groups the write port (we/rd/wd), both read ports (rs1/rd1, rs2/rd2)
// and the debug read handshake (dbg_req/dbg_addr -> dbg_ack/dbg_data).
//   master : datapath / test harness side, drives addresses and write data
//   slave  : register file side, returns read data and debug responses
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  wd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [WIDTH-1:0]  dbg_data;

  modport master (
    output we, rd, wd, rs1, rs2, dbg_req, dbg_addr,
    input  rd1, rd2, dbg_ack, dbg_data
  );

  modport slave (
    input  we, rd, wd, rs1, rs2, dbg_req, dbg_addr,
    output rd1, rd2, dbg_ack, dbg_data
  );

endinterface

// File: rtl/regfile_2r1w_entry.sv
// One storage word of the register file.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-low clear (0 = clear)
//   i_load : load enable, captures i_d on the rising edge
//   i_d    : data to load
//   o_q    : stored word
module regfile_2r1w_entry
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear has priority over load so a reset cycle never lets a write through.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w.sv
// RV32I integer register file with two combinational read ports, one
// synchronous write port and a single-outstanding debug read port.
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-low reset (0 = reset)
//   rf    : slave side of regfile_2r1w_if
//           we/rd/wd        write port (writes to x0 are dropped)
//           rs1/rd1,rs2/rd2 zero-latency read ports
//           dbg_req/dbg_addr -> dbg_ack (one-cycle pulse) / dbg_data (held)
// With BYPASS=1 a write in the current cycle is forwarded to any read port
// (including the debug capture) addressing the same register.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input logic            i_clk,
  input logic            i_rst,
  regfile_2r1w_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] w_entries;
  logic [WIDTH-1:0]            w_rd1;
  logic [WIDTH-1:0]            w_rd2;
  logic [WIDTH-1:0]            w_dbgRead;

  dbg_state_e       r_state;
  dbg_state_e       w_nextState;
  logic             w_dbgAck;
  logic             w_capture;
  logic [WIDTH-1:0] r_dbgData;

  // x0 has no storage; its slot is tied to zero so the read mux can index
  // the array uniformly.
  assign w_entries[0] = '0;

  // One storage word per architectural register x1..x31, each loading only
  // when the write port targets its own index.
  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    regfile_2r1w_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (rf.we && (rf.rd == ADDR_W'(i))),
      .i_d    (rf.wd),
      .o_q    (w_entries[i])
    );
  end

  // Shared read rule: x0 reads zero, then an optional forward of the
  // in-flight write, otherwise the stored word.
  function automatic logic [WIDTH-1:0] readMux(
    input logic [ADDR_W-1:0]           addr,
    input logic                        we,
    input logic [ADDR_W-1:0]           wAddr,
    input logic [WIDTH-1:0]            wData,
    input logic [DEPTH-1:0][WIDTH-1:0] entries
  );
    if (addr == ADDR_W'(X0_ADDR)) begin
      return '0;
    end else if ((BYPASS != 0) && we && (wAddr == addr)) begin
      return wData;
    end else begin
      return entries[addr];
    end
  endfunction

  // Both architectural read ports and the debug capture path use the same
  // rule so a debug read sees exactly what the datapath would see.
  always_comb begin
    w_rd1     = readMux(rf.rs1, rf.we, rf.rd, rf.wd, w_entries);
    w_rd2     = readMux(rf.rs2, rf.we, rf.rd, rf.wd, w_entries);
    w_dbgRead = readMux(rf.dbg_addr, rf.we, rf.rd, rf.wd, w_entries);
  end

  // Debug FSM state register; reset aborts any pending response.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Debug FSM next state and outputs. A request is only accepted in IDLE,
  // so a held request is serviced at most once every two cycles.
  always_comb begin
    w_nextState = r_state;
    w_dbgAck    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rf.dbg_req) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_dbgAck    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Debug data is captured on acceptance and held until the next capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dbgData <= '0;
    end else if (w_capture) begin
      r_dbgData <= w_dbgRead;
    end
  end

  assign rf.rd1      = w_rd1;
  assign rf.rd2      = w_rd2;
  assign rf.dbg_ack  = w_dbgAck;
  assign rf.dbg_data = r_dbgData;

endmodule
